seq_multiplier: RTL and testbench

//   Iterative shift-add multiplier with a start/busy/done handshake and flush.

---
 rtl/seq_multiplier_if.sv | 29 ++
 rtl/seq_multiplier.sv | 121 ++++++++++++
 tb/tb_seq_multiplier.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_if
// Description : Start/busy/done handshake bundle for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 sign;
    logic                 flush;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   z;

    modport master (
        output start, sign, flush, a, b,
        input  busy, done, z
    );

    modport slave (
        input  start, sign, flush, a, b,
        output busy, done, z
    );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Iterative shift-add multiplier retiring BITS_PER_CYCLE bits per
//               clock, with start/busy/done handshake and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    seq_multiplier_if.slave  bus
);
    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]     mreg_q, mreg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 neg_q, neg_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   z_q, z_d;

    logic [WIDTH-1:0]          w_mag_a;
    logic [WIDTH-1:0]          w_mag_b;
    logic [BITS_PER_CYCLE-1:0] w_digit;
    logic [2*WIDTH-1:0]        w_partial;

    // -2^(WIDTH-1) negates onto itself, which is exactly its unsigned magnitude.
    assign w_mag_a   = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_mag_b   = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign w_digit   = mreg_q[BITS_PER_CYCLE-1:0];
    assign w_partial = a_sh_q * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, w_digit};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        mreg_d  = mreg_q;
        acc_d   = acc_q;
        count_d = count_q;
        neg_d   = neg_q;
        z_d     = z_q;
        busy_d  = (state_q == RUN) && !bus.flush;
        done_d  = (state_q == FIX) && !bus.flush;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d = RUN;
                    a_sh_d  = {{WIDTH{1'b0}}, w_mag_a};
                    mreg_d  = w_mag_b;
                    neg_d   = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d   = '0;
                    count_d = CW'(ITER);
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = acc_q + w_partial;
                    a_sh_d  = a_sh_q << BITS_PER_CYCLE;
                    mreg_d  = mreg_q >> BITS_PER_CYCLE;
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    z_d = neg_q ? -acc_q : acc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            mreg_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            mreg_q  <= mreg_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.z    = z_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier (1 and 4 bits/cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    int          sel = 1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    seq_multiplier_if #(.WIDTH(32)) if1 ();
    seq_multiplier_if #(.WIDTH(32)) if4 ();

    assign if1.start = start;  assign if4.start = start;
    assign if1.sign  = sign;   assign if4.sign  = sign;
    assign if1.flush = flush;  assign if4.flush = flush;
    assign if1.a     = a;      assign if4.a     = a;
    assign if1.b     = b;      assign if4.b     = b;

    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave));

    logic        s_busy, s_done;
    logic [63:0] s_z;
    assign s_busy = (sel == 4) ? if4.busy : if1.busy;
    assign s_done = (sel == 4) ? if4.done : if1.done;
    assign s_z    = (sel == 4) ? if4.z    : if1.z;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        sg;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp_z;
    } vec_t;

    function automatic logic [63:0] ref_mul(input logic sg, input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [63:0] sx, sy;
        if (sg) begin
            sx = $signed(x);
            sy = $signed(y);
            return sx * sy;
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues a start on the next edge and returns the index of that edge.
    task automatic start_op(input logic sg, input logic [31:0] x, input logic [31:0] y,
                            output int e0);
        @(negedge clk);
        start = 1'b1; sign = sg; a = x; b = y;
        @(posedge clk);
        #1;
        e0 = cyc;
        start = 1'b0; sign = $urandom_range(0, 1); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int dc, output int bc);
        dc = -1;
        bc = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_done) begin
                dc = cyc;
                break;
            end
            if (s_busy) bc++;
        end
        if (dc < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    vec_t        vecs [10];
    logic [31:0] corners [5];

    initial begin
        int e0, e0b, dc, dc2, bc, seen;
        logic [63:0] prev_z, exp_z;
        logic        sg;
        logic [31:0] x, y;

        vecs[0] = '{1'b0, 32'd3,          32'd5,          64'd15};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'h6,          64'hFFFF_FFFF_FFFF_FFD6};
        vecs[2] = '{1'b0, 32'hFFFF_FFF9,  32'h6,          64'h0000_0005_FFFF_FFD6};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[5] = '{1'b1, 32'd0,          32'hFFFF_FFFF,  64'd0};
        vecs[6] = '{1'b1, 32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000};
        vecs[7] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1};
        vecs[8] = '{1'b0, 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
        vecs[9] = '{1'b1, 32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000};
        corners[0] = 32'd0;          corners[1] = 32'd1;
        corners[2] = 32'hFFFF_FFFF;  corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_busy", {63'd0, if1.busy}, 64'd0);
        chk("reset_done", {63'd0, if1.done}, 64'd0);
        chk("reset_z",    if1.z, 64'd0);
        chk("reset_z4",   if4.z, 64'd0);

        sel = 1;
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].sg, vecs[i].x, vecs[i].y, e0);
            wait_done(dc, bc);
            chk($sformatf("vec%0d_z", i), s_z, vecs[i].exp_z);
            chk($sformatf("vec%0d_lat", i), 64'(dc - e0), 64'd33);
            chk($sformatf("vec%0d_busy", i), 64'(bc), 64'd32);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), {63'd0, s_done}, 64'd0);
        end

        // A second start mid-operation must not disturb the first.
        start_op(1'b0, 32'd3, 32'd5, e0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(dc, bc);
        chk("ignore_z", s_z, 64'd15);
        chk("ignore_lat", 64'(dc - e0), 64'd33);

        // Start held in the done cycle is taken on the very next edge.
        start_op(1'b1, 32'hFFFF_FFF9, 32'd6, e0);
        wait_done(dc, bc);
        start = 1'b1; sign = 1'b0; a = 32'd1000; b = 32'd1000;
        @(posedge clk);
        #1;
        e0b = cyc;
        start = 1'b0;
        chk("b2b_held_z", s_z, 64'hFFFF_FFFF_FFFF_FFD6);
        wait_done(dc2, bc);
        chk("b2b_lat", 64'(dc2 - e0b), 64'd33);
        chk("b2b_edge", 64'(e0b - dc), 64'd1);
        chk("b2b_z", s_z, 64'd1_000_000);

        // Flush in cycle E0+10.
        prev_z = s_z;
        start_op(1'b0, 32'd123, 32'd456, e0);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", {63'd0, s_busy}, 64'd0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (s_done || s_busy) seen++;
        end
        chk("flush_no_done", 64'(seen), 64'd0);
        chk("flush_z_kept", s_z, prev_z);

        // Flush in IDLE wins over a simultaneous start.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (s_done || s_busy) seen++;
        end
        chk("idle_flush_drop", 64'(seen), 64'd0);
        chk("idle_flush_z", s_z, prev_z);

        // Asynchronous reset mid-run.
        start_op(1'b0, 32'd11, 32'd13, e0);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, if1.busy}, 64'd0);
        chk("rst_done", {63'd0, if1.done}, 64'd0);
        chk("rst_z", if1.z, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(1'b0, 32'd11, 32'd13, e0);
        wait_done(dc, bc);
        chk("rst_recover_z", s_z, 64'd143);

        sel = 1;
        for (int i = 0; i < 20; i++) begin
            sg = 1'($urandom_range(0, 1));
            x = $urandom; y = $urandom;
            start_op(sg, x, y, e0);
            wait_done(dc, bc);
            chk("rand1_z", s_z, ref_mul(sg, x, y));
        end

        // Four bits per cycle.
        repeat (40) @(posedge clk);
        sel = 4;
        start_op(1'b0, 32'd3, 32'd5, e0);
        wait_done(dc, bc);
        chk("bpc4_lat", 64'(dc - e0), 64'd9);
        chk("bpc4_busy", 64'(bc), 64'd8);
        chk("bpc4_z", s_z, 64'd15);
        for (int i = 0; i < 1000; i++) begin
            sg = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            exp_z = ref_mul(sg, x, y);
            start_op(sg, x, y, e0);
            wait_done(dc, bc);
            chk($sformatf("rand4_z s=%0d a=%h b=%h", sg, x, y), s_z, exp_z);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
